// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_stream_pkg
// Description : Shared definitions for the CNN feature-map streaming blocks:
//               default beat width, handshake constants, routing-decision
//               encoding and a constant-foldable ceil(log2) helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_stream_pkg;

    // Default width of one feature-map beat.
    localparam int c_DEFAULT_DATA_WIDTH = 16;

    // A beat aimed at a channel that does not exist is always swallowed, so
    // the upstream never deadlocks on a bad select value.
    localparam logic c_READY_ON_DROP = 1'b1;

    // What the demux does with the input beat in the current cycle.
    typedef enum logic [1:0] {
        ROUTE_IDLE  = 2'd0,  // no beat presented
        ROUTE_LOAD  = 2'd1,  // beat written into the target slot
        ROUTE_STALL = 2'd2,  // target slot full and not draining
        ROUTE_DROP  = 2'd3   // target out of range, beat discarded
    } route_e;

    // ceil(log2(value)); returns 0 for value <= 1. Elaboration-time use only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : cnn_stream_pkg
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-entry output holding register with valid/ready. Loading
//               and draining in the same cycle keeps valid high with the new
//               data. Draining without a load clears valid but keeps the data.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset (clears data too)
//               i_load     - write i_data into the slot this cycle
//               i_data     - beat to store
//               i_ready    - downstream consumer ready
//               o_data     - held beat
//               o_valid    - slot holds a beat
//               o_can_load - slot can take a beat this cycle (empty or draining)
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_can_load
);

    logic                  r_valid_q;
    logic                  w_valid_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] w_data_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        if (i_load) begin
            w_valid_d = 1'b1;
            w_data_d  = i_data;
        end else if (r_valid_q && i_ready) begin
            // Data is deliberately left in place after a drain.
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    // Pass-through ready: a full slot can accept when it drains this cycle.
    assign o_can_load = !r_valid_q || i_ready;
    assign o_valid    = r_valid_q;
    assign o_data     = r_data_q;

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/stream_demux_1_to_n.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_to_n
// Description : Registered 1-to-N_OUT stream demultiplexer. Each accepted
//               input beat is written into one per-channel holding slot,
//               chosen by sel (auto_mode=0) or by a round-robin pointer that
//               advances every BURST_LEN accepted beats (auto_mode=1).
//               Beats aimed at a non-existent channel are consumed and
//               flagged with a one-cycle drop_err pulse.
// Ports       : clk        - rising-edge clock
//               reset      - synchronous active-high reset
//               din        - input beat
//               din_valid  - input beat present
//               din_ready  - input accepted on din_valid & din_ready (comb.)
//               sel        - explicit target channel (auto_mode=0)
//               auto_mode  - 1: round-robin routing, 0: sel routing
//               dout       - channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//               dout_valid - per-channel valid
//               dout_ready - per-channel ready
//               cur_ch     - current round-robin pointer
//               drop_err   - pulse one cycle after an out-of-range beat
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_to_n
    import cnn_stream_pkg::*;
#(
    parameter int  DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int  N_OUT      = 5,
    parameter int  BURST_LEN  = 4,
    localparam int SEL_WIDTH  = clog2(N_OUT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic [SEL_WIDTH-1:0]        sel,
    input  logic                        auto_mode,
    output logic [N_OUT*DATA_WIDTH-1:0] dout,
    output logic [N_OUT-1:0]            dout_valid,
    input  logic [N_OUT-1:0]            dout_ready,
    output logic [SEL_WIDTH-1:0]        cur_ch,
    output logic                        drop_err
);

    // Burst counter needs at least one bit even when BURST_LEN is 1.
    localparam int CNT_WIDTH = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;

    // N_OUT widened by one bit so the range test also works when N_OUT is
    // an exact power of two.
    localparam logic [SEL_WIDTH:0]   c_N_OUT_EXT = (SEL_WIDTH + 1)'(N_OUT);
    localparam logic [SEL_WIDTH-1:0] c_PTR_LAST  = SEL_WIDTH'(N_OUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST  = CNT_WIDTH'(BURST_LEN - 1);

    logic [SEL_WIDTH-1:0] w_target;
    logic                 w_in_range;
    logic [N_OUT-1:0]     w_hit;
    logic [N_OUT-1:0]     w_slot_can_load;
    logic [N_OUT-1:0]     w_load;
    logic                 w_tgt_can_load;
    logic                 w_accept;
    route_e               w_route;

    logic [SEL_WIDTH-1:0] r_ptr_q;
    logic [SEL_WIDTH-1:0] w_ptr_d;
    logic [CNT_WIDTH-1:0] r_cnt_q;
    logic [CNT_WIDTH-1:0] w_cnt_d;
    logic                 r_drop_q;
    logic                 w_drop_d;

    // ------------------------------------------------------------------
    // Target selection and ready. Only the target channel's slot state and
    // dout_ready feed din_ready; other channels are masked off by w_hit.
    // ------------------------------------------------------------------
    always_comb begin
        w_target   = auto_mode ? r_ptr_q : sel;
        w_in_range = ({1'b0, w_target} < c_N_OUT_EXT);
        w_hit      = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_hit[k] = (w_target == SEL_WIDTH'(k));
        end
        w_tgt_can_load = |(w_hit & w_slot_can_load);
    end

    always_comb begin
        w_route = ROUTE_IDLE;
        if (din_valid) begin
            if (!w_in_range) begin
                w_route = ROUTE_DROP;
            end else if (w_tgt_can_load) begin
                w_route = ROUTE_LOAD;
            end else begin
                w_route = ROUTE_STALL;
            end
        end
    end

    assign din_ready = w_in_range ? w_tgt_can_load : c_READY_ON_DROP;
    assign w_accept  = (w_route == ROUTE_LOAD) || (w_route == ROUTE_DROP);
    assign w_load    = (w_route == ROUTE_LOAD) ? w_hit : '0;
    assign w_drop_d  = (w_route == ROUTE_DROP);

    // ------------------------------------------------------------------
    // Round-robin pointer / burst counter. In select mode both are pinned
    // at zero so re-entering auto mode always starts a fresh burst on ch0.
    // ------------------------------------------------------------------
    always_comb begin
        w_ptr_d = r_ptr_q;
        w_cnt_d = r_cnt_q;
        if (!auto_mode) begin
            w_ptr_d = '0;
            w_cnt_d = '0;
        end else if (w_accept) begin
            if (r_cnt_q == c_CNT_LAST) begin
                w_cnt_d = '0;
                w_ptr_d = (r_ptr_q == c_PTR_LAST) ? '0 : r_ptr_q + 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_q  <= '0;
            r_cnt_q  <= '0;
            r_drop_q <= 1'b0;
        end else begin
            r_ptr_q  <= w_ptr_d;
            r_cnt_q  <= w_cnt_d;
            r_drop_q <= w_drop_d;
        end
    end

    assign cur_ch   = r_ptr_q;
    assign drop_err = r_drop_q;

    // ------------------------------------------------------------------
    // Per-channel holding slots.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_out_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (reset),
            .i_load     (w_load[k]),
            .i_data     (din),
            .i_ready    (dout_ready[k]),
            .o_data     (dout[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid    (dout_valid[k]),
            .o_can_load (w_slot_can_load[k])
        );
    end

endmodule : stream_demux_1_to_n
`default_nettype wire

// File: tb/tb_stream_demux_1_to_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1_to_n
// Description : Self-checking bench for stream_demux_1_to_n (DATA_WIDTH=16,
//               N_OUT=5, BURST_LEN=4): vector table in select mode, directed
//               burst / mode-switch / reset sequences and a randomized run
//               against a beat-count based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_to_n;

    localparam int DW = 16;
    localparam int N  = 5;
    localparam int BL = 4;

    logic          clk;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [2:0]    sel;
    logic          auto_mode;
    logic [N*DW-1:0] dout;
    logic [N-1:0]  dout_valid;
    logic [N-1:0]  dout_ready;
    logic [2:0]    cur_ch;
    logic          drop_err;

    int n_checks = 0;
    int n_errors = 0;

    stream_demux_1_to_n #(
        .DATA_WIDTH (DW),
        .N_OUT      (N),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sel        (sel),
        .auto_mode  (auto_mode),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .cur_ch     (cur_ch),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: channel contents as arrays, the round-robin pointer
    // derived from the number of beats accepted since auto mode began.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_data  [N];
    logic          m_valid [N];
    logic          m_drop;
    int            m_auto_beats;

    function automatic int m_ptr();
        return (m_auto_beats / BL) % N;
    endfunction

    function automatic int m_target();
        return auto_mode ? m_ptr() : int'(sel);
    endfunction

    function automatic logic m_ready();
        int t;
        t = m_target();
        if (t >= N) return 1'b1;
        return !m_valid[t] || dout_ready[t];
    endfunction

    function automatic logic [N*DW-1:0] m_dout();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = m_data[k];
        return r;
    endfunction

    function automatic logic [N-1:0] m_dvalid();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = m_valid[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
        m_drop       = 1'b0;
        m_auto_beats = 0;
    endtask

    task automatic model_edge();
        int   t;
        logic acc;
        if (reset) begin
            model_clear();
            return;
        end
        t   = m_target();
        acc = din_valid && m_ready();
        for (int k = 0; k < N; k++) begin
            if (acc && t == k) begin
                m_valid[k] = 1'b1;
                m_data[k]  = din;
            end else if (m_valid[k] && dout_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        m_drop = acc && (t >= N);
        if (!auto_mode) m_auto_beats = 0;
        else if (acc)   m_auto_beats++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    // ------------------------------------------------------------------
    // Select-mode vector table, applied from reset in order.
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] din;
        logic          din_valid;
        logic [N-1:0]  rdy;
        logic          exp_ready;
        logic [N-1:0]  exp_valid;
        logic          exp_drop;
        int            chk_ch;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{3'd2, 16'hABCD, 1'b1, 5'b11111, 1'b1, 5'b00100, 1'b0, 2, 16'hABCD};
        vecs[1] = '{3'd6, 16'hDEAD, 1'b1, 5'b11111, 1'b1, 5'b00000, 1'b1, 2, 16'hABCD};
        vecs[2] = '{3'd0, 16'h0F0F, 1'b0, 5'b11111, 1'b1, 5'b00000, 1'b0, 2, 16'hABCD};
        vecs[3] = '{3'd1, 16'h1111, 1'b1, 5'b00000, 1'b1, 5'b00010, 1'b0, 1, 16'h1111};
        vecs[4] = '{3'd1, 16'h2222, 1'b1, 5'b00000, 1'b0, 5'b00010, 1'b0, 1, 16'h1111};
        vecs[5] = '{3'd1, 16'h2222, 1'b1, 5'b11101, 1'b0, 5'b00010, 1'b0, 1, 16'h1111};
        vecs[6] = '{3'd1, 16'h2222, 1'b1, 5'b00010, 1'b1, 5'b00010, 1'b0, 1, 16'h2222};
        vecs[7] = '{3'd3, 16'h3333, 1'b1, 5'b00000, 1'b1, 5'b01010, 1'b0, 3, 16'h3333};
        vecs[8] = '{3'd5, 16'h5555, 1'b1, 5'b00000, 1'b1, 5'b01010, 1'b1, 3, 16'h3333};
        vecs[9] = '{3'd7, 16'h7777, 1'b0, 5'b01000, 1'b1, 5'b00010, 1'b0, 3, 16'h3333};
    end

    initial begin
        int ch;
        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        sel        = '0;
        auto_mode  = 1'b0;
        dout_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();

        // Reset state
        check("reset dout_valid", 128'(dout_valid), 128'(0));
        check("reset dout",       128'(dout),       128'(0));
        check("reset cur_ch",     128'(cur_ch),     128'(0));
        check("reset drop_err",   128'(drop_err),   128'(0));

        // Table: select routing, drain, backpressure, out-of-range drops
        for (int i = 0; i < 10; i++) begin
            sel        = vecs[i].sel;
            din        = vecs[i].din;
            din_valid  = vecs[i].din_valid;
            dout_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d din_ready", i), 128'(din_ready), 128'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d dout_valid", i), 128'(dout_valid), 128'(vecs[i].exp_valid));
            check($sformatf("vec%0d drop_err", i), 128'(drop_err), 128'(vecs[i].exp_drop));
            check($sformatf("vec%0d ch%0d data", i, vecs[i].chk_ch),
                  128'(dout[vecs[i].chk_ch*DW +: DW]), 128'(vecs[i].exp_data));
        end
        din_valid = 1'b0;

        // Auto mode: 22 back-to-back beats, bursts of 4 across 5 channels
        do_reset();
        auto_mode  = 1'b1;
        dout_ready = '1;
        din_valid  = 1'b1;
        for (int i = 0; i < 22; i++) begin
            din = 16'(i);
            #1;
            check($sformatf("auto beat%0d din_ready", i), 128'(din_ready), 128'(1));
            @(posedge clk);
            #1;
            ch = (i / BL) % N;
            check($sformatf("auto beat%0d dout_valid", i), 128'(dout_valid), 128'(1 << ch));
            check($sformatf("auto beat%0d data", i), 128'(dout[ch*DW +: DW]), 128'(i));
            check($sformatf("auto beat%0d cur_ch", i), 128'(cur_ch), 128'(((i + 1) / BL) % N));
        end
        din_valid = 1'b0;

        // Auto mode dropped mid-burst for one cycle, then restored
        do_reset();
        auto_mode  = 1'b1;
        dout_ready = '1;
        din_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            din = 16'h0100 + 16'(i);
            @(posedge clk);
            #1;
        end
        auto_mode = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midburst cur_ch after auto off", 128'(cur_ch), 128'(0));
        auto_mode = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 16'h0200 + 16'(i);
            @(posedge clk);
            #1;
            check($sformatf("restart beat%0d dout_valid", i), 128'(dout_valid), 128'(5'b00001));
            check($sformatf("restart beat%0d data", i), 128'(dout[DW-1:0]), 128'(16'h0200 + 16'(i)));
        end
        check("restart cur_ch after burst", 128'(cur_ch), 128'(1));
        din_valid = 1'b0;

        // Reset dominance while three channels hold data
        do_reset();
        auto_mode  = 1'b0;
        dout_ready = '0;
        din_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = 3'(2 * i);
            din = 16'hC000 + 16'(i);
            @(posedge clk);
            #1;
        end
        check("preload dout_valid", 128'(dout_valid), 128'(5'b10101));
        reset     = 1'b1;
        auto_mode = 1'b1;
        sel       = 3'd1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        din_valid = 1'b0;
        check("midrun reset dout_valid", 128'(dout_valid), 128'(0));
        check("midrun reset dout",       128'(dout),       128'(0));
        check("midrun reset cur_ch",     128'(cur_ch),     128'(0));
        check("midrun reset drop_err",   128'(drop_err),   128'(0));

        // Randomized run against the reference model
        do_reset();
        auto_mode = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset      = ($urandom_range(49, 0) == 0);
            if ($urandom_range(15, 0) == 0) auto_mode = ~auto_mode;
            sel        = 3'($urandom_range(7, 0));
            din_valid  = ($urandom_range(3, 0) != 0);
            dout_ready = 5'($urandom);
            din        = 16'($urandom);
            #1;
            if (!reset) begin
                check($sformatf("rand%0d din_ready", cyc), 128'(din_ready), 128'(m_ready()));
            end
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("rand%0d dout_valid", cyc), 128'(dout_valid), 128'(m_dvalid()));
            check($sformatf("rand%0d dout", cyc),       128'(dout),       128'(m_dout()));
            check($sformatf("rand%0d cur_ch", cyc),     128'(cur_ch),     128'(m_ptr()));
            check($sformatf("rand%0d drop_err", cyc),   128'(drop_err),   128'(m_drop));
        end
        reset     = 1'b0;
        din_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_stream_demux_1_to_n
`default_nettype wire

// File: doc/stream_demux_1_to_n.md
# stream_demux_1_to_n

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshaking. It routes each input beat to one of `N_OUT` per-channel output holding registers. The target is chosen either by an explicit select or by an internal round-robin pointer that advances every `BURST_LEN` accepted beats. It sits between a feature-map reader and the `N_OUT` parallel convolution engines, replacing fixed-width, unregistered 1-to-5 demux instances.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of one beat.
- `N_OUT`, 5, number of output channels, ≥2.
- `BURST_LEN`, 4, accepted beats per channel before the auto pointer advances, ≥1.
- `SEL_WIDTH`, derived localparam = clog2(`N_OUT`), width of `sel` and `cur_ch`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `din` in `DATA_WIDTH`: input beat.
- `din_valid` in 1: input beat present.
- `din_ready` out 1: combinational; the beat is accepted on `din_valid & din_ready`.
- `sel` in `SEL_WIDTH`: explicit target channel, used when `auto_mode`=0.
- `auto_mode` in 1: 1 selects round-robin routing, 0 selects `sel` routing.
- `dout` out `N_OUT*DATA_WIDTH`: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `dout_valid` out `N_OUT`: per-channel valid.
- `dout_ready` in `N_OUT`: per-channel ready.
- `cur_ch` out `SEL_WIDTH`: current round-robin pointer.
- `drop_err` out 1: one-cycle pulse when a beat is discarded because its target is out of range.

## Operation
- Target t = `auto_mode` ? pointer : `sel`.
- Out-of-range target (t ≥ `N_OUT`, possible only in select mode):
  - `din_ready`=1.
  - The beat is consumed and discarded; no channel is written.
  - `drop_err`=1 in the next cycle.
- In-range target: `din_ready` = !`dout_valid`[t] | `dout_ready`[t]. The channel slot is pass-through-ready.
- Accept: `dout`[t] ← `din`, `dout_valid`[t] ← 1.
- Per channel k:
  - `dout_valid`[k] & `dout_ready`[k] with no write this cycle → valid clears; data is held (not zeroed).
  - Simultaneous drain and write → new data loads and valid stays 1.
- Round-robin, `auto_mode`=1:
  - Beat counter cnt increments on each accepted beat.
  - On an accept with cnt = `BURST_LEN`-1: cnt ← 0 and pointer ← (pointer = `N_OUT`-1) ? 0 : pointer+1.
- `auto_mode`=0:
  - pointer and cnt are held at 0.
  - Deasserting `auto_mode` mid-burst clears both on the next edge.
  - Re-asserting it starts at channel 0.
- `auto_mode` or `sel` changing while a beat is stalled retargets that beat. The upstream must hold the beat stable; the demux does not latch the target.
- `dout_ready` of non-target channels never affects `din_ready`.

## Timing
- Reset (synchronous, dominant over all other inputs): all `dout_valid`=0, `dout`=0, pointer=0, cnt=0, `drop_err`=0.
- Reset asserted mid-burst discards every held beat.
- Latency: a beat accepted at edge n appears on `dout_valid`/`dout` after edge n. That is 1 cycle, with no combinational path from `din` to `dout`.
- Throughput: 1 beat/cycle when the target's `dout_ready`=1 continuously.
- `cur_ch` updates on the same edge as the accept that completes a burst.
- `din_ready` combinationally depends on `sel`, `auto_mode`, the target's `dout_valid`, and `dout_ready`[t].

## Structure
- Package `cnn_stream_pkg`: clog2 helper function, default `DATA_WIDTH`, shared handshake constants.
- Sub-module `demux_out_slot`: a one-entry register with valid/ready, load and drain. It is instantiated `N_OUT` times via generate.
- Top module: target mux, ready logic, pointer/counter FSM, drop pulse.

## Test plan
- Select mode, `sel`=2, `din`=0xABCD, all `dout_ready`=1 → `dout_valid`=5'b00100 one cycle later; channel 2 = 0xABCD; other channels unchanged.
- Auto mode, `BURST_LEN`=4, `N_OUT`=5, 22 back-to-back beats 0..21, all ready → beats 0-3 on ch0, 4-7 on ch1, …, 16-19 on ch4, 20-21 on ch0; `cur_ch` wraps 4→0 after beat 19.
- Backpressure: ch1 `dout_ready`=0, two beats with `sel`=1 → first beat held, `din_ready`=0, second beat stalls. Raising `dout_ready`[1] → second beat loads that cycle and valid stays 1.
- `N_OUT`=5, `sel`=6, `din_valid`=1 → `din_ready`=1, no `dout_valid` rises, `drop_err` pulses for exactly 1 cycle.
- Auto mode, 2 beats into a burst on ch0, drop `auto_mode` for 1 cycle then restore → `cur_ch`=0, the next 4 beats go to ch0.
- Reset asserted while 3 channels hold valid data → next cycle all `dout_valid`=0, `dout`=0, `cur_ch`=0, `drop_err`=0.
